// File: rtl/bin_disp_conv.sv
// Binary-to-display converter: WIDTH-bit unsigned value to DIGITS seven-segment
// digits. Hex mode maps nibbles directly. Decimal mode runs a shift-add-3
// (double-dabble) engine, one bit per cycle. Outputs hold until the next
// conversion result, clear or reset.
module bin_disp_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Largest decimal value that fits; 64 bits covers ten digits.
    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;
    localparam logic [SW-1:0] SEG_ZERO = {DIGITS{7'h3F}};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  sh_q;
    logic [BW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;
    logic              mode_q;
    logic              ovf_q;

    logic [63:0]          value_ext_d;
    logic                 dec_ovf_d;
    logic                 hex_ovf_d;
    logic [BW-1:0]        acc_adj_d;
    logic [BW+WIDTH-1:0]  shift_d;
    logic [BW-1:0]        res_bcd_d;
    logic [BW-1:0]        out_bcd_d;
    logic [SW-1:0]        out_seg_d;

    // Overflow detection at capture, add-3 correction and display encoding.
    always_comb begin
        value_ext_d = 64'(value);
        dec_ovf_d   = value_ext_d > DEC_MAX;
        // Bits above the displayable nibbles; always zero when WIDTH <= BW.
        hex_ovf_d   = (value_ext_d >> BW) != 64'd0;

        acc_adj_d = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj_d[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        shift_d = {acc_adj_d, sh_q} << 1;

        // In hex mode sh_q is never shifted, so it still holds the captured value.
        res_bcd_d = mode_q ? acc_q : BW'(sh_q);
        out_bcd_d = ovf_q ? '0 : res_bcd_d;
        out_seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            out_seg_d[7*i +: 7] = ovf_q ? 7'h63 : seg7(res_bcd_d[4*i +: 4]);
        end
    end

    // Control FSM with registered outputs; outputs only move in UPDATE/clear/rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            bcd     <= '0;
            seg     <= SEG_ZERO;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                busy    <= 1'b0;
                ovf     <= 1'b0;
                bcd     <= '0;
                seg     <= SEG_ZERO;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            sh_q    <= value;
                            mode_q  <= mode;
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                            ovf_q   <= mode ? dec_ovf_d : hex_ovf_d;
                            busy    <= 1'b1;
                            state_q <= mode ? SHIFT : UPDATE;
                        end
                    end
                    SHIFT: begin
                        acc_q <= shift_d[BW+WIDTH-1:WIDTH];
                        sh_q  <= shift_d[WIDTH-1:0];
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= UPDATE;
                    end
                    UPDATE: begin
                        bcd     <= out_bcd_d;
                        seg     <= out_seg_d;
                        ovf     <= ovf_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bin_disp_conv.md
Name: bin_disp_conv

Overview:
- Parametrised successor to the board switch-to-display translator.
- Converts a WIDTH-bit unsigned value into DIGITS seven-segment digits, in hex or decimal mode.
- Decimal conversion is a sequential shift-add-3 (double-dabble) engine with a start/busy/done handshake; hex mode is a direct nibble map.
- Sits between the board input conditioning (edge-detected key pulses, switch bus) and the HEX display registers. Outputs hold until the next conversion, clear or reset.

Parameters:
- WIDTH, 8, input value width in bits (1..32).
- DIGITS, 2, number of displayed digits (1..10).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; captures value and mode.
- clear  input  1  synchronous display clear (same effect as rst on outputs).
- mode  input  1  0 = hex, 1 = decimal.
- value  input  WIDTH  number to convert.
- busy  output  1  high while a conversion is in flight.
- done  output  1  one-cycle pulse when outputs update.
- ovf  output  1  value not representable in DIGITS digits of the captured mode.
- bcd  output  4*DIGITS  digit codes, digit 0 in bits [3:0].
- seg  output  7*DIGITS  segment patterns, digit 0 in bits [6:0].

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Priority: rst > clear > start.
- Segment encoding: active-high, bit0 = a … bit6 = g.
  - Digit patterns 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex).
  - Overflow pattern: 7'h63.
- Reset/clear values:
  - state = IDLE, busy = 0, done = 0, ovf = 0, bcd = 0.
  - Every seg digit = 7'h3F (displays 0).
  - clear while busy aborts the conversion and returns to IDLE.
- States: IDLE, SHIFT, UPDATE.
- IDLE, on start:
  - Capture value into shift register sh and mode into mode_q.
  - Zero the BCD accumulator; load count = WIDTH.
  - Compute ovf_q:
    - decimal: value > 10^DIGITS−1 (elaboration-time constant, width-safe compare).
    - hex: WIDTH > 4*DIGITS and any bit above 4*DIGITS−1 set.
  - Next state: mode = 1 → SHIFT; mode = 0 → UPDATE.
- SHIFT, one step per cycle:
  - Each BCD digit ≥ 5 gets +3.
  - Then {acc, sh} shifts left by 1; count decrements.
  - After WIDTH steps, go to UPDATE.
- UPDATE, one cycle:
  - Decimal: bcd = acc.
  - Hex: bcd = captured value zero-extended/truncated to 4*DIGITS bits.
  - seg = per-digit encode of bcd; if ovf_q, every seg digit = 7'h63 and bcd = 0.
  - ovf = ovf_q; done = 1 for this cycle; return to IDLE.
- busy = 1 in SHIFT and UPDATE.
- Latency, counted from the clock edge that samples start:
  - Decimal: outputs and done valid WIDTH+1 cycles later.
  - Hex: outputs and done valid 1 cycle later.
- Handshake rules:
  - start while busy is ignored; no queuing.
  - start in the same cycle done is high is accepted (state is IDLE then).
- Hex mode with 4*DIGITS > WIDTH: upper digits show 0.
- seg, bcd and ovf change only in UPDATE, on clear, or on rst. Mid-conversion values are never exposed.
- value and mode changes after the start cycle have no effect on the current conversion.
- WIDTH = 1 must work (single shift).
- Accumulator has no carry out of digit DIGITS−1; overflow relies solely on ovf_q.

Test Plan:
- WIDTH=8, DIGITS=2, mode=1, value=8'h2A, start at edge t → done=1 after edge t+9; bcd=8'h42; seg={7'h66, 7'h5B}; ovf=0; busy high edges t+1..t+9.
- WIDTH=8, DIGITS=2, mode=1, value=8'd100 → ovf=1; seg={7'h63, 7'h63}; bcd=0. Repeat with value=8'd99 → bcd=8'h99; seg={7'h6F, 7'h6F}; ovf=0.
- WIDTH=8, DIGITS=3, mode=1, value=8'hFF → bcd=12'h255; seg={5B, 6D, 6D}. mode=0, value=8'hA5 → done 1 cycle after start; seg={3F, 77, 6D}; ovf=0.
- WIDTH=8, DIGITS=1, mode=0, value=8'h1F → ovf=1; seg=7'h63.
- start pulsed again 3 cycles into a decimal conversion with a different value → ignored; first result delivered on schedule; exactly one done pulse.
- rst (and separately clear) asserted mid-SHIFT after a previous result 8'h42 was displayed → next cycle busy=0, seg all 7'h3F, bcd=0, ovf=0, no done. clear+start in the same IDLE cycle → start dropped.
